// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  localparam int BYTES_PER_INSTR = 4;
  localparam int PC_INCR         = 4;

endpackage

// File: rtl/fetch_byte_assembler.sv
// Byte counter plus lane-write register that builds a little-endian instruction.
module fetch_byte_assembler
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clr_i,
  input  logic                               en_i,
  input  logic [7:0]                         byte_i,
  output logic [$clog2(BYTES_PER_INSTR)-1:0] byte_cnt_o,
  output logic [DATA_WIDTH-1:0]              instr_o
);

  localparam int CNT_W = $clog2(BYTES_PER_INSTR);

  logic [CNT_W-1:0]      byte_cnt_r;
  logic [DATA_WIDTH-1:0] instr_r;

  // Write the incoming byte into lane byte_cnt and advance; the counter wraps to 0 after the last lane.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_r <= {CNT_W{1'b0}};
      instr_r    <= {DATA_WIDTH{1'b0}};
    end else if (clr_i) begin
      byte_cnt_r <= {CNT_W{1'b0}};
      instr_r    <= instr_r;
    end else if (en_i) begin
      instr_r[{byte_cnt_r, 3'b000} +: 8] <= byte_i;
      byte_cnt_r                         <= byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      byte_cnt_r <= byte_cnt_r;
      instr_r    <= instr_r;
    end
  end

  assign byte_cnt_o = byte_cnt_r;
  assign instr_o    = instr_r;

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, reads four ROM bytes per instruction and hands it to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 8,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]               mem_rdata_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                     misalign_o
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] RESET_PC_C = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] PC_INCR_C  = ADDRESS_WIDTH'(PC_INCR);
  localparam int                       CNT_W      = $clog2(BYTES_PER_INSTR);

  fetch_state_t             state_r;
  logic [ADDRESS_WIDTH-1:0] pc_r;
  logic [ADDRESS_WIDTH-1:0] pc_out_r;
  logic                     valid_r;
  logic [CNT_W-1:0]         byte_cnt_s;
  logic                     asm_en_s;
  logic                     asm_clr_s;
  logic                     handshake_s;
  logic                     last_byte_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                     misalign_r;
`endif

  fetch_byte_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (asm_clr_s),
    .en_i       (asm_en_s),
    .byte_i     (mem_rdata_i),
    .byte_cnt_o (byte_cnt_s),
    .instr_o    (instr_o)
  );

  // Assembler control, handshake detect and ROM address; the ROM is only sampled in FETCH.
  always_comb begin
    asm_en_s    = 1'b0;
    asm_clr_s   = 1'b0;
    handshake_s = 1'b0;
    last_byte_s = 1'b0;
    mem_addr_s  = pc_r;
    if (state_r == FETCH) begin
      mem_addr_s  = pc_r + ADDRESS_WIDTH'(byte_cnt_s);
      asm_en_s    = !redirect_i;
      last_byte_s = (byte_cnt_s == CNT_W'(BYTES_PER_INSTR - 1));
    end else begin
      mem_addr_s = pc_r;
    end
    if (state_r == HOLD) begin
      handshake_s = valid_r && instr_ready_i;
    end else begin
      handshake_s = 1'b0;
    end
    asm_clr_s = redirect_i || handshake_s;
  end

  assign mem_addr_o = mem_addr_s;

  // Main FSM: redirect beats everything, including a handshake in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= FETCH;
      pc_r     <= RESET_PC_C;
      pc_out_r <= RESET_PC_C;
      valid_r  <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_r <= 1'b0;
`endif
    end else if (redirect_i) begin
      pc_r    <= redirect_pc_i;
      valid_r <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_r    <= TRAP;
        misalign_r <= 1'b1;
      end else begin
        state_r    <= FETCH;
        misalign_r <= 1'b0;
      end
`else
      state_r <= FETCH;
`endif
    end else begin
      case (state_r)
        FETCH: begin
          if (last_byte_s) begin
            state_r  <= HOLD;
            valid_r  <= 1'b1;
            pc_out_r <= pc_r;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          if (handshake_s) begin
            state_r <= FETCH;
            valid_r <= 1'b0;
            pc_r    <= pc_r + PC_INCR_C;
          end else begin
            state_r <= HOLD;
          end
        end
        TRAP: begin
          state_r <= TRAP;
          valid_r <= 1'b0;
        end
        default: begin
          state_r <= FETCH;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o          = pc_out_r;
  assign instr_valid_o = valid_r;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_o = misalign_r;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus random redirect/ready traffic
// checked every cycle against a transaction-level model of the fetch sequence.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic [31:0] instr;
  logic [7:0]  pc_o;
  logic        valid;
  logic        ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic [7:0] rom [256];
  assign mem_rdata = rom[mem_addr];

  fetch_seq dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .pc_o          (pc_o),
    .instr_valid_o (valid),
    .instr_ready_i (ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: pc of the word being built/presented, bytes gathered so far (4 = presenting), trap flag.
  int m_pc   = 0;
  int m_have = 0;
  bit m_trap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input int pc);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rom[(pc + i) % 256];
    return w;
  endfunction

  // Model update on each rising edge from the inputs as the DUT sees them.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pc = 0; m_have = 0; m_trap = 1'b0;
    end else if (redirect) begin
      m_pc   = int'(redirect_pc);
      m_have = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_trap = (redirect_pc % 4) != 0;
`endif
    end else if (m_trap) begin
      m_have = 0;
    end else if (m_have == 4) begin
      if (ready) begin
        m_pc   = (m_pc + 4) % 256;
        m_have = 0;
      end
    end else begin
      m_have = m_have + 1;
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_valid;
      logic [7:0] exp_addr;
      exp_valid = !m_trap && (m_have == 4);
      exp_addr  = (m_trap || m_have == 4) ? 8'(m_pc) : 8'((m_pc + m_have) % 256);
      check("valid", {31'd0, valid}, {31'd0, exp_valid});
      check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr});
      if (exp_valid) begin
        check("instr", instr, word_at(m_pc));
        check("pc_o", {24'd0, pc_o}, 32'(m_pc));
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("misalign", {31'd0, misalign}, {31'd0, m_trap});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    if (!valid) begin
      bad++;
      total++;
      $display("FAIL wait_valid: got timeout after %0d cycles expected valid", n);
    end
  endtask

  task automatic do_redirect(input logic [7:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'hA0; rom[3] = 8'h00;
    rom[254] = 8'hAB; rom[255] = 8'hCD;

    #1 rst_ni = 1'b0;
    #2;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_o", {24'd0, pc_o}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // First instruction after reset.
    wait_valid(n);
    check("first_latency", 32'(n), 32'd4);
    check("first_instr", instr, 32'h00A00513);
    check("first_pc", {24'd0, pc_o}, 32'd0);
    tick();
    check("next_addr", {24'd0, mem_addr}, 32'd4);

    // Back-pressure for ten cycles, then accept.
    wait_valid(n);
    check("second_latency", 32'(n), 32'd4);
    ready = 1'b0;
    repeat (10) tick();
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_pc", {24'd0, pc_o}, 32'd4);
    check("hold_addr", {24'd0, mem_addr}, 32'd4);
    ready = 1'b1;
    tick();

    // Redirect while byte 2 is being fetched.
    tick(); tick();
    do_redirect(8'h40);
    wait_valid(n);
    check("redir_latency", 32'(n), 32'd4);
    check("redir_pc", {24'd0, pc_o}, 32'h40);

    // Redirect in the same cycle as a handshake.
    do_redirect(8'h20);
    check("redir_hs_valid", {31'd0, valid}, 32'd0);
    wait_valid(n);
    check("redir_hs_pc", {24'd0, pc_o}, 32'h20);

    // PC wrap-around.
    do_redirect(8'hFC);
    wait_valid(n);
    check("wrap_pc_fc", {24'd0, pc_o}, 32'hFC);
    tick();
    wait_valid(n);
    check("wrap_pc_00", {24'd0, pc_o}, 32'h00);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(8'h21);
    repeat (20) tick();
    check("trap_misalign", {31'd0, misalign}, 32'd1);
    check("trap_valid", {31'd0, valid}, 32'd0);
    check("trap_addr", {24'd0, mem_addr}, 32'h21);
    do_redirect(8'h24);
    check("untrap_misalign", {31'd0, misalign}, 32'd0);
    wait_valid(n);
    check("untrap_latency", 32'(n), 32'd4);
    check("untrap_pc", {24'd0, pc_o}, 32'h24);
`else
    do_redirect(8'hFE);
    wait_valid(n);
    check("misal_pc", {24'd0, pc_o}, 32'hFE);
    check("misal_instr", instr, 32'h0513CDAB);
`endif

    // Random traffic checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      tick();
    end
    redirect = 1'b0;
    ready    = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction fetch sequencer for the single-cycle core's byte-wide instruction ROM. It reads one byte per cycle from the ROM, assembles four bytes little-endian into a 32-bit instruction, and presents it to decode with a valid/ready handshake. It owns the PC: it increments by 4 on each accepted instruction and reloads on a redirect from branch/jump logic.

Parameters:
ADDRESS_WIDTH, 8, byte-address width of the ROM and PC.
DATA_WIDTH, 32, instruction width; fixed at 32 (four bytes).
RESET_PC, 0, PC loaded on reset.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset; asynchronous, active-low.
mem_addr_o  output  ADDRESS_WIDTH  byte address to ROM.
mem_rdata_i  input  8  ROM byte at mem_addr_o; combinational, valid in the same cycle.
redirect_i  input  1  load new PC this cycle.
redirect_pc_i  input  ADDRESS_WIDTH  redirect target.
instr_o  output  DATA_WIDTH  assembled instruction.
pc_o  output  ADDRESS_WIDTH  address of instr_o.
instr_valid_o  output  1  instr_o/pc_o valid.
instr_ready_i  input  1  decode accepts instruction.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, byte_cnt=0, state=FETCH, instr_valid_o=0, instr_o=0, pc_o=RESET_PC.
- States: FETCH, HOLD.
- FETCH: mem_addr_o = pc + byte_cnt, modulo 2^ADDRESS_WIDTH. Each cycle, capture mem_rdata_i into instr lane byte_cnt (bits 8*byte_cnt+7 : 8*byte_cnt), then byte_cnt++. After capturing byte_cnt=3, go to HOLD; instr_valid_o=1 from the next cycle.
- Latency: 4 cycles from entering FETCH to instr_valid_o high. Steady-state throughput is one instruction per 5 cycles when ready is held high.
- HOLD: instr_o, pc_o and instr_valid_o stay stable until a handshake (valid & ready). On handshake: pc = pc + 4 (wrapping), byte_cnt=0, state=FETCH, instr_valid_o=0 next cycle.
- In HOLD, mem_addr_o = pc. The ROM is not sampled.
- Redirect has highest priority in any state:
  - pc = redirect_pc_i, byte_cnt=0, state=FETCH, instr_valid_o=0 next cycle.
  - A partially assembled word is discarded.
- Redirect in the same cycle as a handshake: the instruction counts as consumed, and the redirect target replaces pc+4.
- Wrap-around: pc=0xFE fetches bytes 0xFE, 0xFF, 0x00, 0x01. pc+4 also wraps.
- Misaligned redirect targets (pc[1:0] != 0) are fetched byte-wise as-is unless the optional feature is enabled.
- All outputs are registered except mem_addr_o, which is combinational from registered pc/byte_cnt.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds port misalign_o (output, 1).
  - A redirect with redirect_pc_i[1:0] != 0 enters a third state, TRAP, and asserts misalign_o from the next cycle.
  - In TRAP: instr_valid_o=0, no fetch, mem_addr_o holds the target.
  - Only an aligned redirect leaves TRAP (to FETCH, clearing misalign_o). A misaligned redirect while in TRAP stays in TRAP.
  - Reset clears misalign_o=0.
- Undefined: no misalign_o port, no TRAP state, misaligned fetch as above.

Decomposition:
- Shared package fetch_pkg:
  - enum fetch_state_t {FETCH, HOLD, TRAP}.
  - localparam BYTES_PER_INSTR=4.
  - localparam PC_INCR=4.
- One natural sub-module, fetch_byte_assembler: the 2-bit byte counter plus the lane-write register for instr_o, with clear and enable inputs. The FSM and PC stay in fetch_seq.

Test Plan:
- Reset, ROM[0..3]=13,05,A0,00, ready=1 -> valid in cycle 4, instr_o=0x00A00513, pc_o=0; next fetch starts at address 4.
- ready=0 for 10 cycles in HOLD -> instr_o/pc_o stable, valid held high, mem_addr_o=pc; accept on ready -> pc_o of next instruction=pc+4.
- Redirect to 0x40 during byte 2 of a fetch -> no valid for the partial word; next valid has pc_o=0x40 with ROM[0x40..0x43] data, 4 cycles after redirect.
- Redirect to 0x20 in the same cycle as a handshake -> instruction consumed once; next pc_o=0x20, not pc+4.
- Redirect to 0xFC, ready=1 -> pc_o=0xFC, then pc_o=0x00; redirect 0xFE (feature off) -> bytes from FE, FF, 00, 01.
- With FETCH_MISALIGN_TRAP_EN: redirect 0x21 -> misalign_o=1, valid stays 0 for 20 cycles; redirect 0x24 -> misalign_o=0, valid with pc_o=0x24 four cycles later.
